// File: rtl/xbar_return_arbiter_if.sv
// Return-path arbitration bundle between the slave return FIFOs (R or B)
// and one crossbar master's return FIFO.
//
// Signals:
//   slave_fifo_empty   per-slave return FIFO empty flag
//   slave_dest_master  decoded destination master of each FIFO front entry
//   slave_last         last flag of each FIFO front entry
//   master_fifo_full   this master's return FIFO is full
//   grant_slave_number granted slave index, idle code 2**$clog2(slaves)
//   push_to_fifo       granted slave presents an entry for this master
//   burst_active       arbiter is locked onto a burst
//   beat_count         beats moved in the current / most recent burst
//
// Modports:
//   master  the arbiter, which owns the grant and push side
//   slave   the surrounding FIFOs, which supply status and consume the grant
interface xbar_return_arbiter_if #(
    parameter int masters    = 2,
    parameter int slaves     = 2,
    parameter int BEAT_WIDTH = 9
);
    localparam int DEST_W  = (masters > 1) ? $clog2(masters) : 1;
    localparam int GRANT_W = $clog2(slaves) + 1;

    logic [slaves-1:0]             slave_fifo_empty;
    logic [slaves-1:0][DEST_W-1:0] slave_dest_master;
    logic [slaves-1:0]             slave_last;
    logic                          master_fifo_full;
    logic [GRANT_W-1:0]            grant_slave_number;
    logic                          push_to_fifo;
    logic                          burst_active;
    logic [BEAT_WIDTH-1:0]         beat_count;

    modport master (
        input  slave_fifo_empty,
        input  slave_dest_master,
        input  slave_last,
        input  master_fifo_full,
        output grant_slave_number,
        output push_to_fifo,
        output burst_active,
        output beat_count
    );

    modport slave (
        output slave_fifo_empty,
        output slave_dest_master,
        output slave_last,
        output master_fifo_full,
        input  grant_slave_number,
        input  push_to_fifo,
        input  burst_active,
        input  beat_count
    );
endinterface

// File: rtl/xbar_return_arbiter.sv
// Round-robin return arbiter for one crossbar master. Picks among the slave
// return FIFOs whose front entry is addressed to this master, then stays
// locked on that slave until a beat flagged last has been transferred, so
// bursts are never interleaved.
//
// Ports:
//   ACLK    clock, rising edge
//   ARESET  synchronous active-high reset
//   bus     xbar_return_arbiter_if.master (see interface header)
module xbar_return_arbiter #(
    parameter int masters            = 2,
    parameter int slaves             = 2,
    parameter int i_am_master_number = 0,
    parameter int BEAT_WIDTH         = 9
) (
    input logic                   ACLK,
    input logic                   ARESET,
    xbar_return_arbiter_if.master bus
);
    localparam int GRANT_W = $clog2(slaves) + 1;
    localparam int SEL_W   = (slaves > 1) ? $clog2(slaves) : 1;
    localparam int DEST_W  = (masters > 1) ? $clog2(masters) : 1;

    // The idle code is one past the index range, so it can never alias a slave.
    localparam logic [GRANT_W-1:0]    IDLE_CODE = GRANT_W'(2 ** $clog2(slaves));
    localparam logic [DEST_W-1:0]     ME        = DEST_W'(i_am_master_number);
    localparam logic [BEAT_WIDTH-1:0] BEAT_MAX  = '1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state_q, state_d;
    logic [GRANT_W-1:0]    grant_q, grant_d;
    logic [SEL_W-1:0]      rr_q, rr_d;
    logic [BEAT_WIDTH-1:0] beat_q, beat_d;

    logic [slaves-1:0] eligible;
    logic              found;
    logic [SEL_W-1:0]  pick_idx;
    logic [SEL_W-1:0]  grant_idx;
    logic [SEL_W-1:0]  rr_after;
    logic              push;
    logic              transfer;

    assign grant_idx = grant_q[SEL_W-1:0];

    always_comb begin
        for (int s = 0; s < slaves; s++) begin
            eligible[s] = ~bus.slave_fifo_empty[s] & (bus.slave_dest_master[s] == ME);
        end
    end

    // Scan from rr_q upward with wrap; the first eligible slave wins.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < slaves; k++) begin
            int               cand;
            logic [SEL_W-1:0] cand_idx;
            cand     = (int'(rr_q) + k) % slaves;
            cand_idx = SEL_W'(cand);
            if (!found && eligible[cand_idx]) begin
                found    = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    // Pointer moves one past the slave that just finished; with a single
    // slave this folds to a constant zero.
    assign rr_after = (grant_idx == SEL_W'(slaves - 1)) ? '0 : grant_idx + 1'b1;

    // Reset masks the burst outputs immediately so an abandoned burst cannot
    // push during the reset cycle itself.
    assign push     = (state_q == BURST) & ~bus.slave_fifo_empty[grant_idx] & ~ARESET;
    assign transfer = push & ~bus.master_fifo_full;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                grant_d = IDLE_CODE;
                if (found) begin
                    state_d = BURST;
                    grant_d = GRANT_W'(pick_idx);
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (transfer) begin
                    if (beat_q != BEAT_MAX) begin
                        beat_d = beat_q + 1'b1;
                    end
                    if (bus.slave_last[grant_idx]) begin
                        state_d = IDLE;
                        grant_d = IDLE_CODE;
                        rr_d    = rr_after;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = IDLE_CODE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            grant_q <= IDLE_CODE;
            rr_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

    assign bus.grant_slave_number = grant_q;
    assign bus.push_to_fifo       = push;
    assign bus.burst_active       = (state_q == BURST) & ~ARESET;
    assign bus.beat_count         = beat_q;
endmodule

// File: doc/xbar_return_arbiter.md
XBAR_RETURN_ARBITER -- requirements
Module: xbar_return_arbiter

Interface
REQ-001 SHALL have parameter masters, default 2: number of crossbar masters.
REQ-002 SHALL have parameter slaves, default 2: number of slave return FIFOs (R or B) competing for this master.
REQ-003 SHALL have parameter i_am_master_number, default 0: the master this arbiter serves.
REQ-004 SHALL have parameter BEAT_WIDTH, default 9: width of the beat counter.
REQ-005 SHALL have port ACLK, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port ARESET, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port slave_fifo_empty, input, [slaves] x 1: per-slave return FIFO empty flag.
REQ-008 SHALL have port slave_dest_master, input, [slaves] x $clog2(masters): decoded destination master of each FIFO front entry.
REQ-009 SHALL have port slave_last, input, [slaves] x 1: last flag of each FIFO front entry (RLAST for R; tied 1 for B).
REQ-010 SHALL have port master_fifo_full, input, 1: this master's return FIFO is full.
REQ-011 SHALL have port grant_slave_number, output, $clog2(slaves)+1: granted slave index; idle code = 2**$clog2(slaves), which matches no slave.
REQ-012 SHALL have port push_to_fifo, output, 1: granted slave holds a valid entry for this master.
REQ-013 SHALL have port burst_active, output, 1: high in state BURST.
REQ-014 SHALL have port beat_count, output, BEAT_WIDTH: beats transferred in the current burst.

Function
REQ-015 SHALL treat slave s as eligible when ~slave_fifo_empty[s] & (slave_dest_master[s] == i_am_master_number).
REQ-016 SHALL implement a two-state FSM: IDLE and BURST.
REQ-017 In IDLE, SHALL drive grant_slave_number = idle code and push_to_fifo = 0.
REQ-018 In IDLE with at least one eligible slave, SHALL select the first eligible index at or after rr_ptr, in increasing order modulo slaves.
REQ-019 On that selection, SHALL register the index into grant_slave_number and enter BURST on the next edge, giving one cycle of request-to-grant latency.
REQ-020 In BURST, SHALL drive push_to_fifo = ~slave_fifo_empty[grant].
REQ-021 SHALL define transfer = push_to_fifo & ~master_fifo_full; a transfer pops the granted slave FIFO and pushes the master FIFO in the same cycle.
REQ-022 In BURST, SHALL hold the grant regardless of slave_dest_master and eligibility of other slaves, with no interleaving, until a transfer with slave_last[grant] = 1.
REQ-023 On a transfer with last, SHALL return to IDLE on the next edge and set rr_ptr = (grant+1) mod slaves.
REQ-024 After returning to IDLE, SHALL insert one bubble cycle before the next grant.
REQ-025 While the granted FIFO is empty mid-burst, SHALL drive push_to_fifo = 0 and hold state, grant and beat_count.
REQ-026 While master_fifo_full = 1, SHALL keep push_to_fifo as defined by REQ-020, perform no transfer, and hold state and beat_count.
REQ-027 SHALL increment beat_count on each transfer, saturating at all-ones.
REQ-028 SHALL clear beat_count on entry to BURST.
REQ-029 SHALL hold beat_count in IDLE, so the last burst length stays observable.
REQ-030 SHALL leave rr_ptr unchanged on grant; rr_ptr advances only on burst completion.
REQ-031 With slaves = 1, SHALL compute rr_ptr as constant 0 and still produce the IDLE/BURST sequence.
REQ-032 SHALL keep all outputs registered or derived only from registered state plus slave_fifo_empty.

Reset
REQ-033 While ARESET = 1 at a rising edge, SHALL set state = IDLE, grant_slave_number = idle code, rr_ptr = 0 and beat_count = 0.
REQ-034 While ARESET = 1, SHALL hold push_to_fifo = 0 and burst_active = 0.
REQ-035 SHALL abandon a burst in progress when reset is asserted, with no completion transfer.
REQ-036 SHALL resume arbitration from rr_ptr = 0 after reset.

Verification (masters=2, slaves=3, i_am_master_number=1)
REQ-037 Reset: hold ARESET 2 cycles mid-burst -> next cycle grant=4, push_to_fifo=0, burst_active=0, beat_count=0.
REQ-038 Single burst: slave 2 non-empty, dest=1, 4 beats with last on beat 4, master never full -> grant=2 one cycle after request; push_to_fifo high 4 cycles; beat_count=4; IDLE next; rr_ptr=0.
REQ-039 Round-robin fairness: slaves 0,1,2 all eligible, 1-beat bursts -> grants 0,1,2,0 with one idle cycle between each.
REQ-040 Destination filter: slave 0 non-empty with dest=0, slave 1 with dest=1 -> only slave 1 is granted; grant never equals 0.
REQ-041 Backpressure: master_fifo_full=1 for 3 cycles mid-burst -> push_to_fifo stays 1, beat_count frozen, grant unchanged; burst completes after full drops.
REQ-042 Bubble: granted slave empty 2 cycles mid-burst while slave 0 is eligible -> push_to_fifo=0, grant held, no switch to slave 0 until last.
